// File: rtl/cmsdk_uart_tx_stream_pkg.sv
// Shared types and constants for the byte-stream UART transmitter.
// Holds the frame FSM state encoding and the control characters that
// a downstream UART capture device understands.
package cmsdk_uart_tx_stream_pkg;

  localparam int DATA_W = 8;

  // Index of the last data bit in an 8N1 frame.
  localparam logic [2:0] LAST_BIT = 3'd7;

  // Frame state: idle line, start bit, eight data bits, stop bit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Control characters recognised by the capture device.
  localparam logic [7:0] UART_ESC     = 8'h1B;
  localparam logic [7:0] UART_EOT     = 8'h04;
  localparam logic [7:0] UART_AUX     = 8'h10;
  localparam logic [7:0] UART_DBG_EN  = 8'h11;
  localparam logic [7:0] UART_DBG_DIS = 8'h12;

endpackage

// File: rtl/cmsdk_uart_tx_stream_if.sv
// Byte handshake between a producer and the UART transmitter.
// A byte moves when TX_VALID and TX_READY are both high at a rising clock edge.
interface cmsdk_uart_tx_stream_if;
  import cmsdk_uart_tx_stream_pkg::*;

  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/cmsdk_uart_tx_fifo.sv
// Circular byte buffer sitting between the handshake port and the serialiser.
// Pointers carry one extra wrap bit so that full and empty are distinguishable
// and the fill level is simply their difference.
module cmsdk_uart_tx_fifo
  import cmsdk_uart_tx_stream_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_AW:0]  o_count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]  r_wptr;
  logic [FIFO_AW:0]  r_rptr;
  logic [FIFO_AW:0]  w_count;
  logic              w_push;
  logic              w_pop;

  assign w_count = r_wptr - r_rptr;
  assign o_count = w_count;
  assign o_full  = (w_count == (FIFO_AW + 1)'(DEPTH));
  assign o_empty = (w_count == '0);
  assign o_data  = r_mem[r_rptr[FIFO_AW-1:0]];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage array is written on accepted pushes and needs no reset.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= i_data;
    end
  end

  // Pointers advance independently, so a push and pop together leave the count unchanged.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmsdk_uart_tx_stream.sv
// Byte-stream UART transmitter: buffers incoming bytes and sends each one
// as an 8N1 frame on TXD. Bit period is BAUDDIV+1 clocks, with the divisor
// captured at every frame start so mid-frame changes cannot distort a frame.
module cmsdk_uart_tx_stream
  import cmsdk_uart_tx_stream_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int BAUD_W  = 16
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                ENABLE,
  input  logic [BAUD_W-1:0]   BAUDDIV,
  cmsdk_uart_tx_stream_if.slave tx_if,
  output logic                TXD,
  output logic                BUSY,
  output logic [FIFO_AW:0]    FIFO_COUNT
);

  tx_state_t         r_state;
  tx_state_t         w_stateNxt;
  logic [BAUD_W-1:0] r_bcnt;
  logic [BAUD_W-1:0] w_bcntNxt;
  logic [BAUD_W-1:0] r_div;
  logic [BAUD_W-1:0] w_divNxt;
  logic [2:0]        r_bidx;
  logic [2:0]        w_bidxNxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shiftNxt;
  logic              r_txd;
  logic              w_txdNxt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [FIFO_AW:0]  w_count;
  logic              w_canStart;
  logic              w_boundary;

  // Ready depends only on stored state so a full FIFO never bypasses a same-cycle pop.
  assign tx_if.TX_READY = ~w_full;
  assign w_push         = tx_if.TX_VALID & ~w_full;
  assign w_canStart     = ENABLE & ~w_empty;
  assign w_boundary     = (r_bcnt == '0);

  assign TXD        = r_txd;
  assign FIFO_COUNT = w_count;
  assign BUSY       = (r_state != ST_IDLE) | (w_count != '0);

  cmsdk_uart_tx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .i_push  (w_push),
    .i_data  (tx_if.TX_DATA),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Frame sequencing: next state, baud/bit counters, shifter and next TXD level.
  always_comb begin
    w_stateNxt = r_state;
    w_bcntNxt  = r_bcnt;
    w_divNxt   = r_div;
    w_bidxNxt  = r_bidx;
    w_shiftNxt = r_shift;
    w_pop      = 1'b0;
    w_txdNxt   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_canStart) begin
          w_pop      = 1'b1;
          w_shiftNxt = w_head;
          w_divNxt   = BAUDDIV;
          w_bcntNxt  = BAUDDIV;
          w_stateNxt = ST_START;
        end
      end
      ST_START: begin
        w_txdNxt = 1'b0;
        if (w_boundary) begin
          w_bcntNxt  = r_div;
          w_bidxNxt  = '0;
          w_stateNxt = ST_DATA;
        end else begin
          w_bcntNxt = r_bcnt - 1'b1;
        end
      end
      ST_DATA: begin
        w_txdNxt = r_shift[0];
        if (w_boundary) begin
          w_bcntNxt  = r_div;
          w_shiftNxt = r_shift >> 1;
          if (r_bidx == LAST_BIT) begin
            w_stateNxt = ST_STOP;
          end else begin
            w_bidxNxt = r_bidx + 3'd1;
          end
        end else begin
          w_bcntNxt = r_bcnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (w_boundary) begin
          if (w_canStart) begin
            w_pop      = 1'b1;
            w_shiftNxt = w_head;
            w_divNxt   = BAUDDIV;
            w_bcntNxt  = BAUDDIV;
            w_stateNxt = ST_START;
          end else begin
            w_stateNxt = ST_IDLE;
          end
        end else begin
          w_bcntNxt = r_bcnt - 1'b1;
        end
      end
      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forces the line idle-high at once.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_IDLE;
      r_bcnt  <= '0;
      r_div   <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_stateNxt;
      r_bcnt  <= w_bcntNxt;
      r_div   <= w_divNxt;
      r_bidx  <= w_bidxNxt;
      r_shift <= w_shiftNxt;
      r_txd   <= w_txdNxt;
    end
  end

endmodule

// File: tb/tb_cmsdk_uart_tx_stream.sv
// Self-checking bench for the byte-stream UART transmitter.
// Accepted bytes go into a scoreboard queue; a line monitor decodes every
// 8N1 frame on TXD, checks its shape and compares it with the queue head.
module tb_cmsdk_uart_tx_stream;
  import cmsdk_uart_tx_stream_pkg::*;

  localparam int FIFO_AW = 4;
  localparam int BAUD_W  = 16;

  logic              CLK;
  logic              RESETn;
  logic              ENABLE;
  logic [BAUD_W-1:0] BAUDDIV;
  logic              TXD;
  logic              BUSY;
  logic [FIFO_AW:0]  FIFO_COUNT;

  cmsdk_uart_tx_stream_if txIf ();

  cmsdk_uart_tx_stream #(
    .FIFO_AW (FIFO_AW),
    .BAUD_W  (BAUD_W)
  ) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .ENABLE     (ENABLE),
    .BAUDDIV    (BAUDDIV),
    .tx_if      (txIf.slave),
    .TXD        (TXD),
    .BUSY       (BUSY),
    .FIFO_COUNT (FIFO_COUNT)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int curDiv      = 0;
  logic monEnable = 1'b0;

  logic [7:0] sbQ[$];
  int         startCycQ[$];

  int         monDiv;
  logic [7:0] monByte;
  logic       monGlitch;
  logic [7:0] monExp;

  // Free-running clock and a cycle counter for gap measurements.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Absolute watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line monitor: decodes frames at the current divisor and scores them.
  initial begin
    forever begin
      @(negedge CLK);
      if (monEnable && TXD === 1'b0) begin
        monDiv    = curDiv;
        monGlitch = 1'b0;
        monByte   = '0;
        startCycQ.push_back(cyc);
        for (int c = 1; c <= monDiv; c++) begin
          @(negedge CLK);
          if (TXD !== 1'b0) monGlitch = 1'b1;
        end
        for (int b = 0; b < 8; b++) begin
          for (int c = 0; c <= monDiv; c++) begin
            @(negedge CLK);
            if (c == 0) monByte[b] = TXD;
            else if (TXD !== monByte[b]) monGlitch = 1'b1;
          end
        end
        for (int c = 0; c <= monDiv; c++) begin
          @(negedge CLK);
          if (TXD !== 1'b1) monGlitch = 1'b1;
        end
        if (monEnable) begin
          vectors++;
          if (monGlitch !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL frame_shape: byte %h had uneven bits or bad stop bit (div %0d)", monByte, monDiv);
          end
          vectors++;
          if (sbQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_frame: got %h, expected no frame", monByte);
          end else begin
            monExp = sbQ.pop_front();
            if (monByte !== monExp) begin
              miscompares++;
              $display("[TB] FAIL frame_data: got %h, expected %h", monByte, monExp);
            end
          end
        end
      end
    end
  end

  // Offers one byte from a negedge; returns at the negedge after acceptance with TX_VALID still high.
  task automatic pushByte(input logic [7:0] b);
    int waitCnt;
    waitCnt = 0;
    txIf.TX_DATA  = b;
    txIf.TX_VALID = 1'b1;
    while (txIf.TX_READY !== 1'b1 && waitCnt < 500) begin
      @(negedge CLK);
      waitCnt++;
    end
    if (waitCnt >= 500) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL push_timeout: TX_READY stayed %b, expected 1", txIf.TX_READY);
      txIf.TX_VALID = 1'b0;
    end else begin
      @(posedge CLK);
      sbQ.push_back(b);
      @(negedge CLK);
    end
  endtask

  // Waits until every scored byte has been seen and the DUT is idle.
  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (!(sbQ.size() == 0 && BUSY === 1'b0) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (n >= limit) begin
      miscompares++;
      $display("[TB] FAIL idle_timeout: %0d bytes outstanding, BUSY=%b, expected 0 and 0", sbQ.size(), BUSY);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset();
    RESETn        = 1'b0;
    ENABLE        = 1'b0;
    BAUDDIV       = '0;
    txIf.TX_DATA  = '0;
    txIf.TX_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (TXD !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_txd: got %b expected 1", TXD); end
    vectors++;
    if (txIf.TX_READY !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 1", txIf.TX_READY); end
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", BUSY); end
    vectors++;
    if (FIFO_COUNT !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_count: got %0d expected 0", FIFO_COUNT); end
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    monEnable = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [9:0] expSeq;
    expSeq  = 10'b1_0101_0101_0;
    BAUDDIV = 16'd0;
    curDiv  = 0;
    ENABLE  = 1'b1;
    pushByte(8'h55);
    txIf.TX_VALID = 1'b0;
    vectors++;
    if (TXD !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_n: TXD got %b expected 1", TXD); end
    @(negedge CLK);
    vectors++;
    if (TXD !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_n1: TXD got %b expected 1", TXD); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      vectors++;
      if (TXD !== expSeq[i]) begin
        miscompares++;
        $display("[TB] FAIL bit_seq[%0d]: TXD got %b expected %b", i, TXD, expSeq[i]);
      end
    end
    waitIdle(200);
  endtask

  task automatic test_back_to_back();
    BAUDDIV = 16'd0;
    curDiv  = 0;
    startCycQ.delete();
    pushByte("H");
    pushByte("i");
    pushByte(8'h0A);
    txIf.TX_VALID = 1'b0;
    waitIdle(300);
    vectors++;
    if (startCycQ.size() != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_frames: got %0d frames expected 3", startCycQ.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (startCycQ[i] - startCycQ[i-1] != 10) begin
          miscompares++;
          $display("[TB] FAIL b2b_gap[%0d]: got %0d cycles expected 10", i, startCycQ[i] - startCycQ[i-1]);
        end
      end
    end
  endtask

  task automatic test_baud_div();
    BAUDDIV = 16'd3;
    curDiv  = 3;
    pushByte(8'hA5);
    txIf.TX_VALID = 1'b0;
    repeat (40) @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_in_stop: got %b expected 1", BUSY); end
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_after_stop: got %b expected 0", BUSY); end
    waitIdle(200);
  endtask

  task automatic test_fifo_full();
    BAUDDIV = 16'd0;
    curDiv  = 0;
    ENABLE  = 1'b0;
    for (int i = 0; i < 16; i++) pushByte(8'(8'h30 + i));
    txIf.TX_DATA = 8'hEE;
    vectors++;
    if (txIf.TX_READY !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %b expected 0", txIf.TX_READY); end
    vectors++;
    if (FIFO_COUNT !== 5'd16) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 16", FIFO_COUNT); end
    ENABLE = 1'b1;
    @(negedge CLK);
    vectors++;
    if (FIFO_COUNT !== 5'd15) begin miscompares++; $display("[TB] FAIL full_pop_no_bypass: count got %0d expected 15", FIFO_COUNT); end
    pushByte(8'hEE);
    txIf.TX_VALID = 1'b0;
    waitIdle(2000);
  endtask

  task automatic test_enable_pause();
    int n;
    logic stayedHigh;
    BAUDDIV = 16'd1;
    curDiv  = 1;
    ENABLE  = 1'b1;
    pushByte(8'h3C);
    pushByte(8'hC3);
    txIf.TX_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    ENABLE = 1'b0;
    n = 0;
    while (sbQ.size() != 1 && n < 200) begin @(negedge CLK); n++; end
    vectors++;
    if (n >= 200) begin miscompares++; $display("[TB] FAIL pause_first_done: %0d bytes pending expected 1", sbQ.size()); end
    stayedHigh = 1'b1;
    repeat (30) begin
      @(negedge CLK);
      if (TXD !== 1'b1) stayedHigh = 1'b0;
    end
    vectors++;
    if (stayedHigh !== 1'b1) begin miscompares++; $display("[TB] FAIL pause_line_idle: got %b expected 1", stayedHigh); end
    vectors++;
    if (FIFO_COUNT !== 5'd1) begin miscompares++; $display("[TB] FAIL pause_count: got %0d expected 1", FIFO_COUNT); end
    vectors++;
    if (BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL pause_busy: got %b expected 1", BUSY); end
    ENABLE = 1'b1;
    waitIdle(200);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    BAUDDIV = 16'd3;
    curDiv  = 3;
    pushByte(8'h81);
    pushByte(8'h42);
    txIf.TX_VALID = 1'b0;
    n = 0;
    while (TXD !== 1'b0 && n < 100) begin @(negedge CLK); n++; end
    repeat (10) @(negedge CLK);
    vectors++;
    if (TXD !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_reset_txd: got %b expected 0", TXD); end
    monEnable = 1'b0;
    RESETn    = 1'b0;
    sbQ.delete();
    #1;
    vectors++;
    if (TXD !== 1'b1) begin miscompares++; $display("[TB] FAIL async_reset_txd: got %b expected 1", TXD); end
    vectors++;
    if (FIFO_COUNT !== 5'd0) begin miscompares++; $display("[TB] FAIL async_reset_count: got %0d expected 0", FIFO_COUNT); end
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (50) @(negedge CLK);
    BAUDDIV   = 16'd0;
    curDiv    = 0;
    monEnable = 1'b1;
    pushByte(UART_ESC);
    pushByte(UART_DBG_EN);
    pushByte(UART_EOT);
    txIf.TX_VALID = 1'b0;
    waitIdle(300);
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_baud_div();
    test_fifo_full();
    test_enable_pause();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
